// File: rtl/mesi_isc_cpu_agent.sv
// Per-CPU MESI coherence agent: a direct-mapped state table plus a request FSM and a snoop FSM
// that share one controller port (mbus requests out, cbus snoops/enables in). No data is held.
module mesi_isc_cpu_agent #(
    parameter int LINES          = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_i,
    input  logic                      cpu_wr_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    output logic                      cpu_ack_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o
);
    localparam int IDX_W = $clog2(LINES);

    localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD       = MBUS_CMD_WIDTH'(2);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [2:0] {M_IDLE, M_BROAD, M_WAIT_EN, M_MEM, M_DONE} main_t;
    typedef enum logic [1:0] {S_IDLE, S_WB, S_ACK} snp_t;
    typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;

    mesi_t                 st  [LINES];
    logic [ADDR_WIDTH-1:0] tag [LINES];

    main_t                 main_q, main_nxt;
    snp_t                  snp_q, snp_nxt;
    logic [ADDR_WIDTH-1:0] req_addr_q, snp_addr_q;
    logic                  req_wr_q, snp_wr_q;

    logic [IDX_W-1:0]      cpu_idx, snp_idx, req_idx;
    logic [ADDR_WIDTH-1:0] snp_lk_addr;
    mesi_t                 cpu_st, snp_st, snp_new_st;
    logic                  cpu_hit, snp_hit, snp_is_wr, is_snoop;

    logic                  cpu_take, snp_go, snp_drv, snp_upd;
    logic                  e_to_m, install, en_ok;
    logic [ADDR_WIDTH-1:0] req_addr_nxt, snp_addr_nxt;
    logic                  req_wr_nxt;
    logic [MBUS_CMD_WIDTH-1:0] mb_cmd_nxt;
    logic [ADDR_WIDTH-1:0]     mb_addr_nxt;

    assign cpu_idx = cpu_addr_i[IDX_W-1:0];
    assign req_idx = req_addr_q[IDX_W-1:0];
    assign cpu_st  = st[cpu_idx];
    assign cpu_hit = (cpu_st != ST_I) && (tag[cpu_idx] == cpu_addr_i);

    // A fresh snoop is looked up on the live cbus; a parked write-back uses its latched copy.
    assign is_snoop    = (cbus_cmd_i == CB_WR_SNOOP) || (cbus_cmd_i == CB_RD_SNOOP);
    assign snp_lk_addr = (snp_q == S_IDLE) ? cbus_addr_i : snp_addr_q;
    assign snp_is_wr   = (snp_q == S_IDLE) ? (cbus_cmd_i == CB_WR_SNOOP) : snp_wr_q;
    assign snp_idx     = snp_lk_addr[IDX_W-1:0];
    assign snp_st      = st[snp_idx];
    assign snp_hit     = (snp_st != ST_I) && (tag[snp_idx] == snp_lk_addr);
    assign snp_new_st  = snp_is_wr ? ST_I :
                         ((snp_st == ST_M) || (snp_st == ST_E)) ? ST_S : snp_st;

    always_comb begin
        snp_nxt  = snp_q;
        main_nxt = main_q;
        snp_upd  = 1'b0;
        e_to_m   = 1'b0;
        install  = 1'b0;
        en_ok    = 1'b0;

        // cbus is deaf for the cycle following any ack, so a held command is not re-taken.
        snp_go  = (snp_q == S_IDLE) && is_snoop && !cbus_ack_o;
        snp_drv = (snp_q == S_WB) && (mbus_cmd_o == MB_WR) &&
                  ((main_q == M_IDLE) || (main_q == M_WAIT_EN));

        case (snp_q)
            S_IDLE: begin
                if (snp_go) begin
                    if (snp_hit && (snp_st == ST_M)) begin
                        snp_nxt = S_WB;
                    end else begin
                        snp_nxt = S_ACK;
                        snp_upd = snp_hit;
                    end
                end
            end
            S_WB: begin
                if (snp_drv && mbus_ack_i) begin
                    snp_nxt = S_ACK;
                    snp_upd = snp_hit;
                end
            end
            S_ACK:   snp_nxt = S_IDLE;
            default: snp_nxt = S_IDLE;
        endcase

        cpu_take = (main_q == M_IDLE) && cpu_req_i && (snp_q == S_IDLE) && !is_snoop;

        case (main_q)
            M_IDLE: begin
                if (cpu_take) begin
                    if (cpu_hit && (!cpu_wr_i || (cpu_st == ST_M))) begin
                        main_nxt = M_DONE;
                    end else if (cpu_hit && (cpu_st == ST_E)) begin
                        main_nxt = M_DONE;
                        e_to_m   = 1'b1;
                    end else begin
                        main_nxt = M_BROAD;
                    end
                end
            end
            M_BROAD: if (mbus_ack_i) main_nxt = M_WAIT_EN;
            M_WAIT_EN: begin
                if ((snp_q == S_IDLE) && !cbus_ack_o &&
                    (cbus_cmd_i == (req_wr_q ? CB_EN_WR : CB_EN_RD))) begin
                    main_nxt = M_MEM;
                    en_ok    = 1'b1;
                end
            end
            M_MEM: begin
                if (mbus_ack_i) begin
                    main_nxt = M_DONE;
                    install  = 1'b1;
                end
            end
            M_DONE:  main_nxt = M_IDLE;
            default: main_nxt = M_IDLE;
        endcase

        req_addr_nxt = cpu_take ? cpu_addr_i : req_addr_q;
        req_wr_nxt   = cpu_take ? cpu_wr_i : req_wr_q;
        snp_addr_nxt = snp_go ? cbus_addr_i : snp_addr_q;

        // The request FSM owns mbus in BROAD/MEM; a write-back only slips in around it.
        mb_cmd_nxt  = MB_NOP;
        mb_addr_nxt = '0;
        if (main_nxt == M_BROAD) begin
            mb_cmd_nxt  = req_wr_nxt ? MB_WR_BROAD : MB_RD_BROAD;
            mb_addr_nxt = req_addr_nxt;
        end else if (main_nxt == M_MEM) begin
            mb_cmd_nxt  = req_wr_q ? MB_WR : MB_RD;
            mb_addr_nxt = req_addr_q;
        end else if ((snp_nxt == S_WB) &&
                     ((main_nxt == M_IDLE) || (main_nxt == M_WAIT_EN))) begin
            mb_cmd_nxt  = MB_WR;
            mb_addr_nxt = snp_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q      <= M_IDLE;
            snp_q       <= S_IDLE;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            snp_addr_q  <= '0;
            snp_wr_q    <= 1'b0;
            cpu_ack_o   <= 1'b0;
            cbus_ack_o  <= 1'b0;
            mbus_cmd_o  <= MB_NOP;
            mbus_addr_o <= '0;
            for (int i = 0; i < LINES; i++) begin
                st[i]  <= ST_I;
                tag[i] <= '0;
            end
        end else begin
            main_q      <= main_nxt;
            snp_q       <= snp_nxt;
            req_addr_q  <= req_addr_nxt;
            req_wr_q    <= req_wr_nxt;
            snp_addr_q  <= snp_addr_nxt;
            if (snp_go) snp_wr_q <= (cbus_cmd_i == CB_WR_SNOOP);
            cpu_ack_o   <= (main_nxt == M_DONE);
            cbus_ack_o  <= en_ok || (snp_nxt == S_ACK);
            mbus_cmd_o  <= mb_cmd_nxt;
            mbus_addr_o <= mb_addr_nxt;

            if (snp_upd) st[snp_idx] <= snp_new_st;
            if (e_to_m) st[cpu_idx] <= ST_M;
            // Install overwrites the slot; a dirty victim is the CPU's problem.
            if (install) begin
                st[req_idx]  <= req_wr_q ? ST_M : ST_S;
                tag[req_idx] <= req_addr_q;
            end
        end
    end
endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// Directed scoreboard bench for mesi_isc_cpu_agent: stimulus queues expected output events
// (with their cycle), a negedge monitor pops and compares them as the DUT produces them.
module tb_mesi_isc_cpu_agent;
    localparam int AW = 32;
    localparam logic [2:0] MB_NOP = 3'd0, MB_WR = 3'd1, MB_RD = 3'd2, MB_WRB = 3'd3, MB_RDB = 3'd4;
    localparam logic [2:0] CB_NOP = 3'd0, CB_WRS = 3'd1, CB_RDS = 3'd2, CB_ENW = 3'd3, CB_ENR = 3'd4;
    localparam int EV_MBUS = 0, EV_CBUS = 1, EV_CPU = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req_i = 1'b0, cpu_wr_i = 1'b0, cpu_ack_o;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [2:0]    mbus_cmd_o;
    logic [AW-1:0] mbus_addr_o;
    logic          mbus_ack_i = 1'b0;
    logic [2:0]    cbus_cmd_i = CB_NOP;
    logic [AW-1:0] cbus_addr_i = '0;
    logic          cbus_ack_o;

    typedef struct {
        int            kind;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        int            cyc;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] prev_cmd = MB_NOP;
    bit         drain = 1'b0;
    bit         drained = 1'b0;

    mesi_isc_cpu_agent #(.LINES(4), .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i), .cpu_ack_o(cpu_ack_o),
        .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
        .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic match(input int kind, input logic [2:0] cmd, input logic [AW-1:0] a);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cmd=%0d addr=%0h cyc=%0d, required none",
                     kind, cmd, a, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cmd != cmd || e.addr != a || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind=%0d cmd=%0d addr=%0h cyc=%0d, required kind=%0d cmd=%0d addr=%0h cyc=%0d",
                         kind, cmd, a, cyc, e.kind, e.cmd, e.addr, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (cpu_ack_o || cbus_ack_o || mbus_cmd_o != MB_NOP || mbus_addr_o != '0) begin
                errors++;
                $display("FAIL reset_outputs: got cpu_ack=%0b cbus_ack=%0b mbus_cmd=%0d mbus_addr=%0h, required all 0",
                         cpu_ack_o, cbus_ack_o, mbus_cmd_o, mbus_addr_o);
            end
            prev_cmd = MB_NOP;
        end else begin
            if (cbus_ack_o) match(EV_CBUS, MB_NOP, '0);
            if (mbus_cmd_o != MB_NOP && prev_cmd == MB_NOP) match(EV_MBUS, mbus_cmd_o, mbus_addr_o);
            if (cpu_ack_o) match(EV_CPU, MB_NOP, '0);
            prev_cmd = mbus_cmd_o;
        end
        if (drain && !drained) begin
            while (sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: got nothing, required kind=%0d cmd=%0d addr=%0h cyc=%0d",
                         e.kind, e.cmd, e.addr, e.cyc);
            end
            drained = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [2:0] cmd, input logic [AW-1:0] a, input int c);
        ev_t e;
        e.kind = kind; e.cmd = cmd; e.addr = a; e.cyc = c;
        sb.push_back(e);
    endtask

    // Miss up to WAIT_EN: broadcast is held two cycles before the controller accepts it.
    task automatic miss_start(input bit wr, input logic [AW-1:0] a);
        cpu_req_i = 1'b1; cpu_wr_i = wr; cpu_addr_i = a;
        push(EV_MBUS, wr ? MB_WRB : MB_RDB, a, cyc + 1);
        step(); step();
        mbus_ack_i = 1'b1;
        step();
        mbus_ack_i = 1'b0;
    endtask

    // From WAIT_EN: optional wrong-type enable first (must be ignored), then EN, MEM, ack.
    task automatic miss_finish(input bit wr, input logic [AW-1:0] a, input bit bad_en);
        if (bad_en) begin
            cbus_cmd_i = wr ? CB_ENR : CB_ENW; cbus_addr_i = a;
            step(); step();
        end
        cbus_cmd_i = wr ? CB_ENW : CB_ENR; cbus_addr_i = ~a;
        push(EV_CBUS, MB_NOP, '0, cyc + 1);
        push(EV_MBUS, wr ? MB_WR : MB_RD, a, cyc + 1);
        step();
        cbus_cmd_i = CB_NOP;
        step();
        mbus_ack_i = 1'b1;
        push(EV_CPU, MB_NOP, '0, cyc + 1);
        step();
        mbus_ack_i = 1'b0; cpu_req_i = 1'b0;
        step();
    endtask

    task automatic cpu_hit(input bit wr, input logic [AW-1:0] a);
        cpu_req_i = 1'b1; cpu_wr_i = wr; cpu_addr_i = a;
        push(EV_CPU, MB_NOP, '0, cyc + 1);
        step();
        cpu_req_i = 1'b0;
        step();
    endtask

    task automatic snoop(input logic [2:0] cmd, input logic [AW-1:0] a, input bit wb);
        cbus_cmd_i = cmd; cbus_addr_i = a;
        if (wb) begin
            push(EV_MBUS, MB_WR, a, cyc + 1);
            step(); step();
            mbus_ack_i = 1'b1;
            push(EV_CBUS, MB_NOP, '0, cyc + 1);
            step();
            mbus_ack_i = 1'b0;
        end else begin
            push(EV_CBUS, MB_NOP, '0, cyc + 1);
            step();
        end
        cbus_cmd_i = CB_NOP;
        step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b1;
        step();

        // read miss 0x5 -> S, then read hit
        miss_start(1'b0, 32'h5);
        miss_finish(1'b0, 32'h5, 1'b0);
        cpu_hit(1'b0, 32'h5);

        // write to S line upgrades via broadcast, then write hit on M
        miss_start(1'b1, 32'h5);
        miss_finish(1'b1, 32'h5, 1'b0);
        cpu_hit(1'b1, 32'h5);

        // 0x7 in M: RD_SNOOP writes back and downgrades to S; second snoop has no write-back
        miss_start(1'b1, 32'h7);
        miss_finish(1'b1, 32'h7, 1'b0);
        snoop(CB_RDS, 32'h7, 1'b1);
        snoop(CB_RDS, 32'h7, 1'b0);

        // WR_SNOOP miss at index 1 leaves 0x5 in M
        snoop(CB_WRS, 32'h9, 1'b0);
        cpu_hit(1'b1, 32'h5);

        // 0x6 read with a wrong-type enable ignored; then write with invalidating snoop in WAIT_EN
        miss_start(1'b0, 32'h6);
        miss_finish(1'b0, 32'h6, 1'b1);
        miss_start(1'b1, 32'h6);
        snoop(CB_WRS, 32'h6, 1'b0);
        miss_finish(1'b1, 32'h6, 1'b0);
        cpu_hit(1'b1, 32'h6);

        // simultaneous write req and RD_SNOOP on M line: snoop first, CPU then sees S and broadcasts
        cpu_req_i = 1'b1; cpu_wr_i = 1'b1; cpu_addr_i = 32'h5;
        cbus_cmd_i = CB_RDS; cbus_addr_i = 32'h5;
        push(EV_MBUS, MB_WR, 32'h5, cyc + 1);
        step(); step();
        mbus_ack_i = 1'b1;
        push(EV_CBUS, MB_NOP, '0, cyc + 1);
        step();
        mbus_ack_i = 1'b0; cbus_cmd_i = CB_NOP;
        push(EV_MBUS, MB_WRB, 32'h5, cyc + 2);
        step(); step();
        mbus_ack_i = 1'b1;
        step();
        mbus_ack_i = 1'b0;
        miss_finish(1'b1, 32'h5, 1'b0);

        // reset in MEM: outputs clear at once, table is wiped so 0x4 misses afterwards
        miss_start(1'b0, 32'h4);
        miss_finish(1'b0, 32'h4, 1'b0);
        miss_start(1'b1, 32'h4);
        cbus_cmd_i = CB_ENW; cbus_addr_i = 32'h4;
        push(EV_CBUS, MB_NOP, '0, cyc + 1);
        push(EV_MBUS, MB_WR, 32'h4, cyc + 1);
        step();
        cbus_cmd_i = CB_NOP;
        step();
        rst = 1'b0;
        cpu_req_i = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        miss_start(1'b0, 32'h4);
        miss_finish(1'b0, 32'h4, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        drain = 1'b1;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesi_isc_cpu_agent.md
# mesi_isc_cpu_agent

Per-CPU coherence agent that sits on one port of the MESI intersystem coherence controller. It drives that port's main bus (mbus: broadcasts plus memory RD/WR) and consumes its coherence bus (cbus: snoops plus enables). It keeps a direct-mapped MESI state table for a small set of lines and turns CPU read/write requests into the controller's broadcast / enable / memory-access protocol. It answers snoops with write-backs and state downgrades. The agent holds coherence state only, no data.

## Interface
- LINES, 4: state-table entries, power of 2; index = addr[log2(LINES)-1:0]
- ADDR_WIDTH, 32: address width
- MBUS_CMD_WIDTH, 3: mbus command width; NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4
- CBUS_CMD_WIDTH, 3: cbus command width; NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  CPU request valid, held until cpu_ack_o
- cpu_wr_i  in  1  1=write, 0=read, stable while cpu_req_i
- cpu_addr_i  in  ADDR_WIDTH  request address, stable while cpu_req_i
- cpu_ack_o  out  1  one-cycle completion pulse
- mbus_cmd_o  out  MBUS_CMD_WIDTH  main bus command to controller
- mbus_addr_o  out  ADDR_WIDTH  main bus address
- mbus_ack_i  in  1  controller accepted mbus command (one cycle)
- cbus_cmd_i  in  CBUS_CMD_WIDTH  coherence command from controller, held until acked
- cbus_addr_i  in  ADDR_WIDTH  coherence address
- cbus_ack_o  out  1  one-cycle acknowledge of cbus command

## Operation
- Table entry = {state[1:0], addr[ADDR_WIDTH-1:0]}; state I=0, S=1, E=2, M=3. Hit = state!=I and stored addr == request addr.
- Main FSM: IDLE, BROAD, WAIT_EN, MEM, DONE.
  - IDLE: takes cpu_req_i only when snoop FSM is S_IDLE and cbus_cmd_i is not a snoop.
    - Read hit (S/E/M) -> DONE.
    - Write hit M -> DONE. Write hit E -> M, then DONE.
    - Otherwise latch addr/type -> BROAD.
  - BROAD: mbus_cmd_o=RD_BROAD or WR_BROAD, mbus_addr_o=latched addr, held until mbus_ack_i -> WAIT_EN.
  - WAIT_EN: on cbus_cmd_i EN_RD (read) or EN_WR (write), pulse cbus_ack_o -> MEM. The latched address is used; cbus_addr_i is ignored. An EN of the wrong type is not acked (protocol error, held).
  - MEM: mbus_cmd_o=RD or WR, held until mbus_ack_i. On ack, install entry (read -> S, write -> M), evicting any other address at that index. Conflict-miss victims in M are not written back here; a write-back before eviction is the CPU's responsibility. -> DONE.
  - DONE: cpu_ack_o=1 for one cycle -> IDLE.
- Snoop FSM: S_IDLE, S_WB, S_ACK. A snoop is accepted in S_IDLE when cbus_cmd_i is WR_SNOOP or RD_SNOOP and no ack was pulsed last cycle.
  - Line M: go to S_WB. mbus_cmd_o=WR to cbus_addr_i, held until mbus_ack_i, then S_ACK.
  - Line not M, or miss: go directly to S_ACK.
  - S_ACK: pulse cbus_ack_o. Same edge updates state: WR_SNOOP -> I; RD_SNOOP M/E -> S, S unchanged. Miss leaves the table unchanged.
- mbus ownership: S_WB may drive mbus only while the main FSM is IDLE or WAIT_EN. Otherwise it waits in S_WB with mbus_cmd_o driven by the main FSM. The main FSM never enters BROAD/MEM while snoop FSM != S_IDLE.
- A snoop that invalidates the pending line during WAIT_EN does not cancel the request. The entry is installed normally in MEM.
- cbus commands other than snoops are ignored outside WAIT_EN. NOP is never acked.

## Timing
- Reset (rst=0, asynchronous): cpu_ack_o=0, cbus_ack_o=0, mbus_cmd_o=NOP, mbus_addr_o=0, all entries I, both FSMs idle. A reset mid-transaction drops the request with no ack.
- Hit latency: cpu_req_i sampled at edge N -> cpu_ack_o high in cycle N+1.
- Miss: req at N -> mbus broadcast from N+1. mbus_ack_i at A -> WAIT_EN from A+1. EN seen at E -> cbus_ack_o and mbus RD/WR in E+1. mbus_ack_i at K -> cpu_ack_o and state update in K+1.
- Snoop seen at S, no write-back -> cbus_ack_o in S+1.
- Snoop with write-back -> mbus WR from S+1 (if mbus free). mbus_ack_i at W -> cbus_ack_o in W+1.
- cbus_ack_o and cpu_ack_o are exactly one cycle. After cbus_ack_o the agent ignores cbus_cmd_i for one cycle.
- mbus_cmd_o returns to NOP in the cycle after mbus_ack_i unless a new command starts.
- Simultaneous cpu_req_i and snoop in IDLE: snoop is served first, and the CPU lookup sees the post-snoop state.

## Test plan
- Read miss addr 0x5: req -> RD_BROAD@0x5 held until mbus_ack_i. EN_RD -> cbus_ack_o one cycle plus mbus RD@0x5. mbus_ack_i -> cpu_ack_o next cycle, entry 1 = S.
- Write to S line 0x5: WR_BROAD, EN_WR, WR. Entry becomes M. A second write to 0x5 -> cpu_ack_o one cycle after req, mbus stays NOP.
- Line 0x7 in M, RD_SNOOP@0x7: mbus WR@0x7 next cycle. mbus_ack_i -> cbus_ack_o next cycle, entry = S.
- WR_SNOOP@0x9 on a miss: cbus_ack_o one cycle later, no mbus activity, table unchanged.
- In WAIT_EN for write 0x6 (S), WR_SNOOP@0x6 arrives: acked and entry goes I. EN_WR then completes, entry = M, cpu_ack_o asserted.
- rst low during MEM: all outputs 0/NOP immediately. After release, a read of the same address misses and issues RD_BROAD.
